// File: rtl/cr_had_pkg.sv
// Shared encodings for the HAD debug-request scheduler: FSM states, cause codes
// and the fixed source-priority function.
package cr_had_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DBG  = 2'd2,
        ST_EXIT = 2'd3
    } sched_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_DR    = 3'd1,
        CAUSE_ADR   = 3'd2,
        CAUSE_JDB   = 3'd3,
        CAUSE_MBKPT = 3'd4,
        CAUSE_TRACE = 3'd5,
        CAUSE_OTHER = 3'd6
    } cause_e;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    // Fixed priority DR > ADR > JDB > MBKPT > TRACE.
    function automatic cause_e pick_cause(input logic dr, input logic adr, input logic jdb,
                                          input logic mbkpt, input logic trace);
        if (dr)         return CAUSE_DR;
        else if (adr)   return CAUSE_ADR;
        else if (jdb)   return CAUSE_JDB;
        else if (mbkpt) return CAUSE_MBKPT;
        else if (trace) return CAUSE_TRACE;
        else            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/cr_had_dbgreq_sched.sv
// Debug-request scheduler: arbitrates debug sources into one held request to the
// core, tracks ack/timeout, records the entry cause and sequences debug exit.
module cr_had_dbgreq_sched
    import cr_had_pkg::*;
(
    input  logic       cpuclk,
    input  logic       hadrst_b,
    input  logic       req_dr,
    input  logic       req_adr,
    input  logic       req_jdb,
    input  logic       req_mbkpt,
    input  logic       req_trace,
    input  logic       iu_had_dbg_ack,
    input  logic       iu_yy_xx_dbgon,
    input  logic       iu_had_dbg_disable_for_tee,
    input  logic       exit_req,
    input  logic [7:0] regs_timeout_val,
    output logic       sched_iu_dbg_req,
    output logic [2:0] sched_iu_req_type,
    output logic [2:0] sched_regs_cause,
    output logic       sched_regs_cause_vld,
    output logic       sched_regs_timeout,
    output logic       sched_exit_dbg,
    output logic       sched_busy
);

    sched_state_e state_q, state_d;
    logic         pend_dr_q, pend_dr_d;
    logic         pend_adr_q, pend_adr_d;
    logic         pend_jdb_q, pend_jdb_d;
    cause_e       req_type_q, req_type_d;
    logic         dbg_req_q, dbg_req_d;
    logic [7:0]   cnt_q, cnt_d;
    cause_e       cause_q, cause_d;
    logic         cause_vld_q, cause_vld_d;
    logic         timeout_q, timeout_d;
    logic         exit_dbg_q, exit_dbg_d;

    logic         eff_dr, eff_adr, eff_jdb;
    logic         timeout_hit;
    cause_e       best;

    // Pulses arriving this cycle are eligible immediately, not only once latched.
    assign eff_dr      = pend_dr_q  | req_dr;
    assign eff_adr     = pend_adr_q | req_adr;
    assign eff_jdb     = pend_jdb_q | req_jdb;
    assign best        = pick_cause(eff_dr, eff_adr, eff_jdb, req_mbkpt, req_trace);
    assign timeout_hit = (regs_timeout_val != 8'd0) && (cnt_q == regs_timeout_val);

    always_comb begin
        // NOTE: every _d takes a default before the case so no path can infer a latch.
        state_d     = state_q;
        pend_dr_d   = pend_dr_q;
        pend_adr_d  = pend_adr_q;
        pend_jdb_d  = pend_jdb_q;
        req_type_d  = CAUSE_NONE;
        dbg_req_d   = 1'b0;
        cnt_d       = cnt_q;
        cause_d     = cause_q;
        cause_vld_d = 1'b0;
        timeout_d   = 1'b0;
        exit_dbg_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pend_dr_d  = eff_dr;
                pend_adr_d = eff_adr;
                pend_jdb_d = eff_jdb;
                if (iu_yy_xx_dbgon) begin
                    state_d     = ST_DBG;
                    cause_d     = CAUSE_OTHER;
                    cause_vld_d = 1'b1;
                    pend_dr_d   = 1'b0;
                    pend_adr_d  = 1'b0;
                    pend_jdb_d  = 1'b0;
                end else if (!iu_had_dbg_disable_for_tee && (best != CAUSE_NONE)) begin
                    state_d    = ST_REQ;
                    req_type_d = best;
                    dbg_req_d  = 1'b1;
                    cnt_d      = 8'd0;
                end
            end
            ST_REQ: begin
                pend_dr_d  = eff_dr;
                pend_adr_d = eff_adr;
                pend_jdb_d = eff_jdb;
                if (iu_had_dbg_ack) begin
                    state_d     = ST_DBG;
                    cause_d     = req_type_q;
                    cause_vld_d = 1'b1;
                    pend_dr_d   = 1'b0;
                    pend_adr_d  = 1'b0;
                    pend_jdb_d  = 1'b0;
                end else if (timeout_hit) begin
                    // Drop only the source that was granted; others get their turn.
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    case (req_type_q)
                        CAUSE_DR:  pend_dr_d  = 1'b0;
                        CAUSE_ADR: pend_adr_d = 1'b0;
                        CAUSE_JDB: pend_jdb_d = 1'b0;
                        default:   ;
                    endcase
                end else begin
                    req_type_d = req_type_q;
                    dbg_req_d  = 1'b1;
                    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
                end
            end
            ST_DBG: begin
                if (!iu_yy_xx_dbgon) begin
                    state_d = ST_IDLE;
                end else if (exit_req) begin
                    state_d    = ST_EXIT;
                    exit_dbg_d = 1'b1;
                end
            end
            ST_EXIT: begin
                if (!iu_yy_xx_dbgon) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpuclk or negedge hadrst_b) begin
        if (!hadrst_b) begin
            state_q     <= ST_IDLE;
            pend_dr_q   <= 1'b0;
            pend_adr_q  <= 1'b0;
            pend_jdb_q  <= 1'b0;
            req_type_q  <= CAUSE_NONE;
            dbg_req_q   <= 1'b0;
            cnt_q       <= 8'd0;
            cause_q     <= CAUSE_NONE;
            cause_vld_q <= 1'b0;
            timeout_q   <= 1'b0;
            exit_dbg_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge _d values together.
            state_q     <= state_d;
            pend_dr_q   <= pend_dr_d;
            pend_adr_q  <= pend_adr_d;
            pend_jdb_q  <= pend_jdb_d;
            req_type_q  <= req_type_d;
            dbg_req_q   <= dbg_req_d;
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            cause_vld_q <= cause_vld_d;
            timeout_q   <= timeout_d;
            exit_dbg_q  <= exit_dbg_d;
        end
    end

    assign sched_iu_dbg_req     = dbg_req_q;
    assign sched_iu_req_type    = req_type_q;
    assign sched_regs_cause     = cause_q;
    assign sched_regs_cause_vld = cause_vld_q;
    assign sched_regs_timeout   = timeout_q;
    assign sched_exit_dbg       = exit_dbg_q;
    assign sched_busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cr_had_dbgreq_sched.sv
// Scoreboard bench for cr_had_dbgreq_sched: a behavioural model predicts output
// events per cycle; a negedge monitor pops and compares whenever the DUT shows one.
module tb_cr_had_dbgreq_sched;

    logic       cpuclk;
    logic       hadrst_b;
    logic       req_dr, req_adr, req_jdb, req_mbkpt, req_trace;
    logic       iu_had_dbg_ack, iu_yy_xx_dbgon, iu_had_dbg_disable_for_tee, exit_req;
    logic [7:0] regs_timeout_val;
    logic       sched_iu_dbg_req;
    logic [2:0] sched_iu_req_type;
    logic [2:0] sched_regs_cause;
    logic       sched_regs_cause_vld;
    logic       sched_regs_timeout;
    logic       sched_exit_dbg;
    logic       sched_busy;

    cr_had_dbgreq_sched dut (
        .cpuclk                     (cpuclk),
        .hadrst_b                   (hadrst_b),
        .req_dr                     (req_dr),
        .req_adr                    (req_adr),
        .req_jdb                    (req_jdb),
        .req_mbkpt                  (req_mbkpt),
        .req_trace                  (req_trace),
        .iu_had_dbg_ack             (iu_had_dbg_ack),
        .iu_yy_xx_dbgon             (iu_yy_xx_dbgon),
        .iu_had_dbg_disable_for_tee (iu_had_dbg_disable_for_tee),
        .exit_req                   (exit_req),
        .regs_timeout_val           (regs_timeout_val),
        .sched_iu_dbg_req           (sched_iu_dbg_req),
        .sched_iu_req_type          (sched_iu_req_type),
        .sched_regs_cause           (sched_regs_cause),
        .sched_regs_cause_vld       (sched_regs_cause_vld),
        .sched_regs_timeout         (sched_regs_timeout),
        .sched_exit_dbg             (sched_exit_dbg),
        .sched_busy                 (sched_busy)
    );

    initial cpuclk = 1'b0;
    always #5 cpuclk = ~cpuclk;

    int cycle_cnt = 0;
    always @(posedge cpuclk) cycle_cnt <= cycle_cnt + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle_cnt);
    endtask

    task automatic fail(input string name, input longint act, input longint exp);
        n_total++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle_cnt);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int cyc;
        bit rise;
        int rtype;
        bit cvld;
        int cause;
        bit tmo;
        bit ext;
    } ev_t;

    typedef enum int {M_IDLE, M_REQ, M_DBG, M_EXIT} mmode_e;

    ev_t    exp_q[$];
    mmode_e m_mode;
    bit     m_pend [1:3];
    int     m_type;
    int     m_wait;

    task automatic model_reset();
        m_mode = M_IDLE;
        for (int i = 1; i <= 3; i++) m_pend[i] = 1'b0;
        m_type = 0;
        m_wait = 0;
        exp_q.delete();
    endtask

    // Applies the rules to the inputs currently driven; events appear after the next edge.
    task automatic model_step();
        ev_t e;
        bit  src [1:5];
        bit  emit;
        int  best;
        int  waited;
        src[1] = req_dr;
        src[2] = req_adr;
        src[3] = req_jdb;
        src[4] = req_mbkpt;
        src[5] = req_trace;
        e = '{default: 0};
        e.cyc = cycle_cnt + 1;
        emit = 1'b0;
        case (m_mode)
            M_IDLE: begin
                for (int i = 1; i <= 3; i++) m_pend[i] = m_pend[i] | src[i];
                if (iu_yy_xx_dbgon) begin
                    m_mode = M_DBG;
                    for (int i = 1; i <= 3; i++) m_pend[i] = 1'b0;
                    e.cvld = 1'b1; e.cause = 6; emit = 1'b1;
                end else if (!iu_had_dbg_disable_for_tee) begin
                    best = 0;
                    for (int i = 5; i >= 1; i--)
                        if ((i <= 3) ? m_pend[i] : src[i]) best = i;
                    if (best != 0) begin
                        m_mode = M_REQ; m_type = best; m_wait = 0;
                        e.rise = 1'b1; e.rtype = best; emit = 1'b1;
                    end
                end
            end
            M_REQ: begin
                for (int i = 1; i <= 3; i++) m_pend[i] = m_pend[i] | src[i];
                waited = (m_wait > 255) ? 255 : m_wait;
                if (iu_had_dbg_ack) begin
                    m_mode = M_DBG;
                    for (int i = 1; i <= 3; i++) m_pend[i] = 1'b0;
                    e.cvld = 1'b1; e.cause = m_type; emit = 1'b1;
                end else if (regs_timeout_val != 0 && waited == int'(regs_timeout_val)) begin
                    m_mode = M_IDLE;
                    if (m_type <= 3) m_pend[m_type] = 1'b0;
                    e.tmo = 1'b1; emit = 1'b1;
                end else begin
                    m_wait++;
                end
            end
            M_DBG: begin
                if (!iu_yy_xx_dbgon) m_mode = M_IDLE;
                else if (exit_req) begin
                    m_mode = M_EXIT;
                    e.ext = 1'b1; emit = 1'b1;
                end
            end
            M_EXIT: begin
                if (!iu_yy_xx_dbgon) m_mode = M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
        if (emit) exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    bit   mon_on = 1'b0;
    logic prev_req = 1'b0;

    always @(negedge cpuclk) begin : monitor
        bit  rise;
        ev_t e;
        if (!hadrst_b || !mon_on) begin
            prev_req = 1'b0;
        end else begin
            rise = sched_iu_dbg_req && !prev_req;
            prev_req = sched_iu_dbg_req;
            if (!sched_iu_dbg_req) check("req_type_outside_req", sched_iu_req_type, 0);
            if (rise || sched_regs_cause_vld || sched_regs_timeout || sched_exit_dbg) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_event", {rise, sched_regs_cause_vld, sched_regs_timeout, sched_exit_dbg}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_cycle", cycle_cnt, e.cyc);
                    check("ev_req_rise", rise, e.rise);
                    check("ev_cause_vld", sched_regs_cause_vld, e.cvld);
                    check("ev_timeout", sched_regs_timeout, e.tmo);
                    check("ev_exit_dbg", sched_exit_dbg, e.ext);
                    if (e.rise) check("ev_req_type", sched_iu_req_type, e.rtype);
                    if (e.cvld) check("ev_cause", sched_regs_cause, e.cause);
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cycle_cnt) begin
                e = exp_q.pop_front();
                fail("missed_event_cycle", cycle_cnt, e.cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit dr, input bit adr, input bit jdb, input bit mb, input bit tr,
                         input bit ack, input bit dbgon, input bit tee, input bit ex);
        req_dr = dr; req_adr = adr; req_jdb = jdb; req_mbkpt = mb; req_trace = tr;
        iu_had_dbg_ack = ack; iu_yy_xx_dbgon = dbgon;
        iu_had_dbg_disable_for_tee = tee; exit_req = ex;
        model_step();
        @(posedge cpuclk);
        #1;
    endtask

    task automatic idle(input bit dbgon, input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, dbgon, 0, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int  high, tmo_seen;
        bit  cdbg, jdb_lvl, tee_lvl, ack;
        int  tv_list [5];
        tv_list = '{0, 1, 4, 7, 2};

        hadrst_b = 1'b0;
        req_dr = 0; req_adr = 0; req_jdb = 0; req_mbkpt = 0; req_trace = 0;
        iu_had_dbg_ack = 0; iu_yy_xx_dbgon = 0; iu_had_dbg_disable_for_tee = 0; exit_req = 0;
        regs_timeout_val = 8'd0;
        repeat (3) @(posedge cpuclk);
        #1;
        check("rst_dbg_req", sched_iu_dbg_req, 0);
        check("rst_req_type", sched_iu_req_type, 0);
        check("rst_cause", sched_regs_cause, 0);
        check("rst_cause_vld", sched_regs_cause_vld, 0);
        check("rst_timeout", sched_regs_timeout, 0);
        check("rst_exit_dbg", sched_exit_dbg, 0);
        check("rst_busy", sched_busy, 0);
        hadrst_b = 1'b1;
        model_reset();
        mon_on = 1'b1;
        idle(0, 2);

        // DR and TRACE together: DR wins; ack records cause 1; then exit sequence.
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
        check("dr_trace_req", sched_iu_dbg_req, 1);
        check("dr_trace_type", sched_iu_req_type, 1);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        check("ack_cause_vld", sched_regs_cause_vld, 1);
        check("ack_cause", sched_regs_cause, 1);
        idle(1, 1);
        check("cause_vld_single", sched_regs_cause_vld, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        check("exit_pulse", sched_exit_dbg, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        check("exit_pulse_single", sched_exit_dbg, 0);
        check("exit_busy", sched_busy, 1);
        idle(1, 2);
        idle(0, 1);
        check("exit_to_idle", sched_busy, 0);

        // Timeout 4 without ack: request held five cycles, then one timeout pulse.
        regs_timeout_val = 8'd4;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        high = 0;
        tmo_seen = 0;
        for (int i = 0; i < 12; i++) begin
            high += int'(sched_iu_dbg_req);
            tmo_seen += int'(sched_regs_timeout);
            idle(0, 1);
        end
        check("tmo_req_cycles", high, 5);
        check("tmo_pulses", tmo_seen, 1);
        check("tmo_idle", sched_busy, 0);

        // Ack on the timeout cycle wins.
        regs_timeout_val = 8'd2;
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 2);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        check("ack_tmo_cause_vld", sched_regs_cause_vld, 1);
        check("ack_tmo_timeout", sched_regs_timeout, 0);
        check("ack_tmo_cause", sched_regs_cause, 2);
        idle(0, 1);

        // TEE disable blocks entry but keeps the ADR pending.
        regs_timeout_val = 8'd0;
        drive(0, 1, 0, 0, 0, 0, 0, 1, 0);
        check("tee_block_1", sched_busy, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("tee_block_2", sched_busy, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("tee_release_req", sched_iu_dbg_req, 1);
        check("tee_release_type", sched_iu_req_type, 2);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle(0, 1);

        // Counter saturates: after >255 cycles a limit of 255 matches at once.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 300);
        regs_timeout_val = 8'd255;
        idle(0, 1);
        check("sat_timeout", sched_regs_timeout, 1);
        check("sat_idle", sched_busy, 0);
        regs_timeout_val = 8'd0;
        idle(0, 1);

        // Reset asserted while a request is outstanding.
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("mbkpt_type", sched_iu_req_type, 4);
        #1;
        hadrst_b = 1'b0;
        model_reset();
        #1;
        check("rst_req_dbg_req", sched_iu_dbg_req, 0);
        check("rst_req_type_0", sched_iu_req_type, 0);
        check("rst_req_cause", sched_regs_cause, 0);
        check("rst_req_busy", sched_busy, 0);
        @(posedge cpuclk);
        #1;
        hadrst_b = 1'b1;
        model_reset();
        idle(0, 1);
        check("rst_release_idle", sched_busy, 0);

        // Randomized traffic across several timeout settings.
        cdbg = 0; jdb_lvl = 0; tee_lvl = 0;
        foreach (tv_list[p]) begin
            regs_timeout_val = 8'(tv_list[p]);
            for (int i = 0; i < 600; i++) begin
                ack = (m_mode == M_REQ) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
                if (ack && m_mode == M_REQ) cdbg = 1;
                else if (cdbg && $urandom_range(0, 9) == 0) cdbg = 0;
                else if (!cdbg && $urandom_range(0, 79) == 0) cdbg = 1;
                if ($urandom_range(0, 24) == 0) jdb_lvl = !jdb_lvl;
                if ($urandom_range(0, 19) == 0) tee_lvl = !tee_lvl;
                drive($urandom_range(0, 11) == 0, $urandom_range(0, 13) == 0, jdb_lvl,
                      $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0,
                      ack, cdbg, tee_lvl, $urandom_range(0, 4) == 0);
            end
        end

        // Drain: short timeout flushes any leftover pendings back to IDLE.
        regs_timeout_val = 8'd1;
        idle(0, 30);
        @(negedge cpuclk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("final_idle", sched_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cr_had_dbgreq_sched.md
CR_HAD_DBGREQ_SCHED -- requirements
Module: cr_had_dbgreq_sched

Interface
REQ-001 SHALL have port: cpuclk  in  1  core clock; all flops rise-edge.
REQ-002 SHALL have port: hadrst_b  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: req_dr  in  1  debug-request (DR) pulse.
REQ-004 SHALL have port: req_adr  in  1  async debug-request (ADR) pulse.
REQ-005 SHALL have port: req_jdb  in  1  pin debug-request level.
REQ-006 SHALL have port: req_mbkpt  in  1  memory breakpoint hit, level, valid only when sampled.
REQ-007 SHALL have port: req_trace  in  1  trace hit, level, valid only when sampled.
REQ-008 SHALL have port: iu_had_dbg_ack  in  1  one-cycle pulse: core accepted request.
REQ-009 SHALL have port: iu_yy_xx_dbgon  in  1  core in debug mode.
REQ-010 SHALL have port: iu_had_dbg_disable_for_tee  in  1  debug entry forbidden.
REQ-011 SHALL have port: exit_req  in  1  exit-debug pulse from JTAG update.
REQ-012 SHALL have port: regs_timeout_val  in  8  ack timeout in cycles; 0 = never.
REQ-013 SHALL have port: sched_iu_dbg_req  out  1  request to core, held until ack/timeout.
REQ-014 SHALL have port: sched_iu_req_type  out  3  cause code of outstanding request.
REQ-015 SHALL have port: sched_regs_cause  out  3  cause of last debug entry.
REQ-016 SHALL have port: sched_regs_cause_vld  out  1  one-cycle pulse on cause update.
REQ-017 SHALL have port: sched_regs_timeout  out  1  one-cycle pulse on ack timeout.
REQ-018 SHALL have port: sched_exit_dbg  out  1  one-cycle registered exit pulse.
REQ-019 SHALL have port: sched_busy  out  1  state != IDLE.

Function
REQ-020 Cause codes SHALL be: 0 none, 1 DR, 2 ADR, 3 JDB, 4 MBKPT, 5 TRACE, 6 OTHER.
REQ-021 DR/ADR/JDB SHALL set sticky pending bits (pend_dr/adr/jdb) in IDLE/REQ; ignored in DBG/EXIT.
REQ-022 Priority SHALL be DR > ADR > JDB > MBKPT > TRACE; MBKPT/TRACE are sampled, never latched.
REQ-023 FSM states SHALL be IDLE, REQ, DBG, EXIT (2-bit encoding).
REQ-024 IDLE: iu_yy_xx_dbgon=1 SHALL go DBG, cause=6, cause_vld pulse, pending cleared.
REQ-025 IDLE: any eligible source, dbgon=0, tee_disable=0 SHALL go REQ next cycle, latch type, counter=0.
REQ-026 tee_disable=1 SHALL block IDLE->REQ; pending bits retained.
REQ-027 REQ: sched_iu_dbg_req=1 and req_type stable; new higher-priority pendings SHALL NOT preempt.
REQ-028 REQ: ack SHALL go DBG, cause=req_type, cause_vld pulse, all pending bits cleared.
REQ-029 REQ: counter SHALL increment per cycle, saturating at 255.
REQ-030 REQ: counter==regs_timeout_val (nonzero) and no ack SHALL go IDLE, timeout pulse, clear granted pending bit only.
REQ-031 Ack and timeout in same cycle: ack SHALL win, no timeout pulse.
REQ-032 DBG: exit_req && dbgon SHALL go EXIT with sched_exit_dbg=1 for exactly the first EXIT cycle.
REQ-033 EXIT: dbgon=0 SHALL go IDLE; exit_req in EXIT ignored.
REQ-034 DBG: dbgon falling without exit_req SHALL go IDLE.
REQ-035 sched_iu_req_type SHALL be 0 outside REQ.

Reset
REQ-036 Reset SHALL force IDLE; all outputs 0, cause 0, pending 0, counter 0, from any state.
REQ-037 Deassertion SHALL be synchronized externally; block makes no assumption on first cycle inputs.

Structure
REQ-038 Cause codes and state encodings SHALL live in shared package cr_had_pkg.
REQ-039 Single module; no sub-module; approx. 200 lines.

Verification
REQ-040 req_dr and req_trace same cycle in IDLE -> REQ, req_type=1; ack -> cause=1, cause_vld one pulse.
REQ-041 timeout_val=4, no ack -> dbg_req high 5 cycles, timeout pulse, IDLE; pend_dr cleared.
REQ-042 Ack on timeout cycle -> DBG, cause_vld=1, timeout=0.
REQ-043 In DBG, exit_req -> exit_dbg single pulse; dbgon low 3 cycles later -> IDLE.
REQ-044 tee_disable=1 plus req_adr -> stays IDLE; tee_disable drops -> REQ with type=2.
REQ-045 Reset asserted in REQ -> all outputs 0 same cycle, IDLE after release.
